// File: rtl/reflex_timer_pkg.sv
// reflex_timer_pkg: shared FSM encoding, LFSR constants and timebase constants for the reaction timer.
package reflex_timer_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_GO, S_DONE} state_t;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int TICK_PERIOD_CLK = 5_000_000;
    localparam int DELAY_MIN_DEF = 10;
    localparam int DELAY_SPAN_LOG2_DEF = 4;
    localparam int MAX_REACT_DEF = 50;
    localparam int RES_W_DEF = 8;
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/reflex_timer_if.sv
// reflex_timer_if: game-side signals of one reaction-test round.
interface reflex_timer_if #(parameter int RES_W = 8);
    logic             tick_in;
    logic             start;
    logic             btn;
    logic             go_led;
    logic             busy;
    logic [RES_W-1:0] result;
    logic             result_valid;
    logic             false_start;
    logic             timeout;
    modport master (output tick_in, start, btn,
                    input  go_led, busy, result, result_valid, false_start, timeout);
    modport slave  (input  tick_in, start, btn,
                    output go_led, busy, result, result_valid, false_start, timeout);
endinterface

// File: rtl/reflex_timer_edge_sync.sv
// edge_sync: 2-FF synchronizer followed by a one-clk rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);
    logic [2:0] r_sh;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sh <= '0;
        else        r_sh <= {r_sh[1:0], i_d};
    assign o_rise = r_sh[1] & ~r_sh[2];
endmodule

// File: rtl/reflex_timer.sv
// reflex_timer: one reaction-test round paced by the 100 ms tick; reports latency, false start or timeout.
module reflex_timer
    import reflex_timer_pkg::*;
#(
    parameter int DELAY_MIN       = DELAY_MIN_DEF,
    parameter int DELAY_SPAN_LOG2 = DELAY_SPAN_LOG2_DEF,
    parameter int MAX_REACT       = MAX_REACT_DEF,
    parameter int RES_W           = RES_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    reflex_timer_if.slave bus
);
    state_t           r_state, w_state_n;
    logic             r_tick_q;
    logic [7:0]       r_lfsr;
    logic [RES_W-1:0] r_delay, w_delay_n;
    logic [RES_W-1:0] r_react, w_react_n;
    logic [RES_W-1:0] r_result, w_result_n;
    logic             r_valid, w_valid_n;
    logic             r_fs, w_fs_n;
    logic             r_to, w_to_n;
    logic             w_tick_rise;
    logic             w_btn_rise;
    logic [RES_W-1:0] w_delay_load;

    edge_sync u_btn (.clk(clk), .rst_n(rst_n), .i_d(bus.btn), .o_rise(w_btn_rise));

    assign w_tick_rise  = bus.tick_in & ~r_tick_q;
    assign w_delay_load = RES_W'(DELAY_MIN) + RES_W'(r_lfsr[DELAY_SPAN_LOG2-1:0]);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_tick_q <= 1'b0;
            r_lfsr   <= LFSR_SEED;
            r_delay  <= '0;
            r_react  <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_fs     <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_tick_q <= bus.tick_in;
            r_lfsr   <= lfsr_next(r_lfsr);
            r_delay  <= w_delay_n;
            r_react  <= w_react_n;
            r_result <= w_result_n;
            r_valid  <= w_valid_n;
            r_fs     <= w_fs_n;
            r_to     <= w_to_n;
        end

    // A button edge always beats a tick landing on the same clock.
    always_comb begin
        w_state_n  = r_state;
        w_delay_n  = r_delay;
        w_react_n  = r_react;
        w_result_n = r_result;
        w_valid_n  = r_valid;
        w_fs_n     = r_fs;
        w_to_n     = r_to;
        case (r_state)
            S_IDLE, S_DONE:
                if (bus.start) begin
                    w_state_n  = S_ARM;
                    w_delay_n  = w_delay_load;
                    w_result_n = '0;
                    w_valid_n  = 1'b0;
                    w_fs_n     = 1'b0;
                    w_to_n     = 1'b0;
                end
            S_ARM:
                if (w_btn_rise) begin
                    w_state_n = S_DONE;
                    w_fs_n    = 1'b1;
                end else if (w_tick_rise) begin
                    w_state_n = (r_delay == RES_W'(1)) ? S_GO : S_ARM;
                    w_delay_n = r_delay - RES_W'(1);
                    w_react_n = '0;
                end
            S_GO:
                if (w_btn_rise) begin
                    w_state_n  = S_DONE;
                    w_result_n = r_react;
                    w_valid_n  = 1'b1;
                end else if (w_tick_rise) begin
                    if (r_react == RES_W'(MAX_REACT - 1)) begin
                        w_state_n  = S_DONE;
                        w_result_n = RES_W'(MAX_REACT);
                        w_to_n     = 1'b1;
                    end else begin
                        w_react_n = r_react + RES_W'(1);
                    end
                end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign bus.go_led       = (r_state == S_GO);
    assign bus.busy         = (r_state == S_ARM) || (r_state == S_GO);
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.false_start  = r_fs;
    assign bus.timeout      = r_to;
endmodule

// File: tb/tb_reflex_timer.sv
// tb_reflex_timer: randomized and directed rounds checked every cycle against a behavioural round model.
module tb_reflex_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reflex_timer_if #(.RES_W(8)) bus();
    reflex_timer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0, errors = 0;
    int phase = 0;
    bit b_lvl = 1'b0, r_lvl = 1'b0, saw_go = 1'b0;

    // model: mode 0 idle, 1 waiting for GO, 2 GO, 3 done
    int m_mode, m_dleft, m_react, m_result;
    bit m_valid, m_fs, m_to, m_tq;
    bit [2:0] m_bh;
    logic [7:0] m_lfsr;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_dleft = 0; m_react = 0; m_result = 0;
        m_valid = 0; m_fs = 0; m_to = 0; m_tq = 0; m_bh = '0;
        m_lfsr = 8'hA5;
    endtask

    // Predicts the state after the coming clock edge from the inputs now applied.
    task automatic m_step();
        bit trise, brise;
        if (!rst_n) begin m_reset(); return; end
        trise = bus.tick_in && !m_tq;
        brise = m_bh[1] && !m_bh[2];
        if (m_mode == 0 || m_mode == 3) begin
            if (bus.start) begin
                m_mode = 1; m_dleft = 10 + int'(m_lfsr & 8'h0F);
                m_result = 0; m_valid = 0; m_fs = 0; m_to = 0;
            end
        end else if (m_mode == 1) begin
            if (brise) begin m_mode = 3; m_fs = 1; end
            else if (trise) begin
                m_dleft--;
                if (m_dleft == 0) begin m_mode = 2; m_react = 0; end
            end
        end else begin
            if (brise) begin m_mode = 3; m_result = m_react; m_valid = 1; end
            else if (trise) begin
                m_react++;
                if (m_react == 50) begin m_mode = 3; m_result = 50; m_to = 1; end
            end
        end
        m_tq = bus.tick_in;
        m_bh = {m_bh[1:0], bus.btn};
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    always @(negedge clk) begin
        chk("go_led", bus.go_led, m_mode == 2);
        chk("busy", bus.busy, m_mode == 1 || m_mode == 2);
        chk("result", bus.result, m_result);
        chk("result_valid", bus.result_valid, m_valid);
        chk("false_start", bus.false_start, m_fs);
        chk("timeout", bus.timeout, m_to);
    end

    task automatic cyc(input bit st);
        @(negedge clk);
        #1;
        saw_go |= bus.go_led;
        rst_n = r_lvl;
        bus.start = st;
        bus.btn = b_lvl;
        bus.tick_in = (phase < 10);
        phase = (phase + 1) % 20;
        m_step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic ticks(input int n);
        int c = 0;
        while (c < n) begin
            if (phase == 0) c++;
            cyc(1'b0);
        end
    endtask

    task automatic wait_go();
        bit ok = 1'b0;
        for (int i = 0; i < 800 && !ok; i++) begin
            if (bus.go_led) ok = 1'b1;
            else cyc(1'b0);
        end
        if (!ok) chk("wait_go_budget", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 1600 && !ok; i++) begin
            if (!bus.busy) ok = 1'b1;
            else cyc(1'b0);
        end
        if (!ok) chk("wait_idle_budget", 0, 1);
    endtask

    task automatic press(input int n);
        b_lvl = 1'b1; idle(n); b_lvl = 1'b0;
    endtask

    initial begin
        int c;
        bus.start = 1'b0; bus.btn = 1'b0; bus.tick_in = 1'b0;
        m_reset();
        idle(3);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        r_lvl = 1'b1;
        idle(5);

        // no button: delay window, then timeout
        c = 0;
        cyc(1'b1);
        for (int i = 0; i < 800 && !bus.go_led; i++) begin
            if (phase == 0) c++;
            cyc(1'b0);
        end
        chk("go_delay_in_10_25", int'(c >= 10 && c <= 25), 1);
        wait_idle();
        chk("to_timeout", bus.timeout, 1);
        chk("to_result", bus.result, 50);
        chk("to_valid", bus.result_valid, 0);
        chk("to_go_led", bus.go_led, 0);

        // press 3 ticks after GO
        cyc(1'b1); wait_go(); ticks(3); press(4); wait_idle();
        chk("r3_result", bus.result, 3);
        chk("r3_valid", bus.result_valid, 1);
        chk("r3_false_start", bus.false_start, 0);
        chk("r3_busy", bus.busy, 0);

        // press 2 ticks after start
        saw_go = 1'b0;
        cyc(1'b1); ticks(2); press(4); wait_idle();
        chk("fs_flag", bus.false_start, 1);
        chk("fs_no_go", saw_go, 0);
        chk("fs_valid", bus.result_valid, 0);

        // button edge on the final wait tick
        saw_go = 1'b0;
        cyc(1'b1);
        for (int i = 0; i < 800 && !(m_mode == 1 && m_dleft == 1 && phase == 18); i++) cyc(1'b0);
        press(4); wait_idle();
        chk("tie_arm_fs", bus.false_start, 1);
        chk("tie_arm_no_go", saw_go, 0);

        // button edge on a GO tick: that tick is not counted
        cyc(1'b1); wait_go();
        for (int i = 0; i < 800 && !(m_mode == 2 && m_react == 2 && phase == 18); i++) cyc(1'b0);
        press(4); wait_idle();
        chk("tie_go_result", bus.result, 2);
        chk("tie_go_valid", bus.result_valid, 1);

        // start ignored in ARM and GO; start in DONE restarts
        cyc(1'b1); idle(30); cyc(1'b1); wait_go(); idle(5); cyc(1'b1); ticks(1); press(4); wait_idle();
        chk("ign_result", bus.result, 1);
        chk("ign_valid", bus.result_valid, 1);
        cyc(1'b1); cyc(1'b0);
        chk("restart_busy", bus.busy, 1);
        chk("restart_valid", bus.result_valid, 0);
        chk("restart_result", bus.result, 0);
        press(4); wait_idle();

        // reset in the middle of GO
        cyc(1'b1); wait_go(); ticks(2); idle(3);
        @(negedge clk);
        #3;
        r_lvl = 1'b0; rst_n = 1'b0; m_reset();
        #1;
        chk("mid_rst_go", bus.go_led, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_result", bus.result, 0);
        idle(3);
        r_lvl = 1'b1;
        idle(2);
        cyc(1'b1); wait_go(); ticks(4); press(3); wait_idle();
        chk("post_rst_result", bus.result, 4);

        // random rounds
        for (int r = 0; r < 20; r++) begin
            cyc(1'b1);
            c = $urandom_range(0, 500);
            for (int i = 0; i < c; i++) cyc($urandom_range(0, 40) == 0);
            press($urandom_range(1, 6));
            wait_idle();
            idle($urandom_range(0, 10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
